// File: rtl/board_pkg.sv
// Shared board-level types for the SDRAM read-port arbiter.
// State and requester enums are kept here so debug probes decode them by name.
package board_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_WAIT = 2'd1,
        BG_WAIT  = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_BG  = 1'b1
    } sdr_requester_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Toggle-handshake bundle around the arbiter: CPU fill port, GA25 fetch port, SDRAM controller port.
// 'master' is the arbiter's view; 'slave' is the view of the requesters and controller around it.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 25
);
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_req;
    logic              cpu_rdy;
    logic [63:0]       cpu_data;

    logic [ADDR_W-1:0] bg_addr;
    logic              bg_64bit;
    logic              bg_req;
    logic              bg_rdy;
    logic [63:0]       bg_data;

    logic [ADDR_W-1:0] sdr_addr;
    logic              sdr_64bit;
    logic              sdr_req;
    logic              sdr_rdy;
    logic [63:0]       sdr_data;

    logic              busy;

    modport master (
        input  cpu_addr, cpu_req, bg_addr, bg_64bit, bg_req, sdr_rdy, sdr_data,
        output cpu_rdy, cpu_data, bg_rdy, bg_data, sdr_addr, sdr_64bit, sdr_req, busy
    );

    modport slave (
        output cpu_addr, cpu_req, bg_addr, bg_64bit, bg_req, sdr_rdy, sdr_data,
        input  cpu_rdy, cpu_data, bg_rdy, bg_data, sdr_addr, sdr_64bit, sdr_req, busy
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM read port between the CPU ROM fill and GA25 tile fetch, video first,
// with a starvation limit on consecutive BG grants while the CPU waits.
module sdram_arbiter
    import board_pkg::*;
#(
    parameter int ADDR_W       = 25,
    parameter int BG_BURST_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    sdram_arbiter_if.master bus
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(BG_BURST_MAX);

    arb_state_t          state;
    sdr_requester_t      owner;
    logic [STARVE_W-1:0] starve;

    logic [ADDR_W-1:0] sdr_addr_q;
    logic              sdr_64bit_q;
    logic              sdr_req_q;
    logic              cpu_rdy_q;
    logic              bg_rdy_q;
    logic [63:0]       cpu_data_q;
    logic [63:0]       bg_data_q;
    logic              busy_q;

    logic pend_cpu;
    logic pend_bg;
    logic grant_bg;
    logic grant_cpu;

    // BG wins unless the CPU has already been passed over BG_BURST_MAX times in a row.
    always_comb begin
        pend_cpu  = bus.cpu_req ^ cpu_rdy_q;
        pend_bg   = bus.bg_req ^ bg_rdy_q;
        grant_bg  = pend_bg && !(pend_cpu && (starve == STARVE_MAX));
        grant_cpu = !grant_bg && pend_cpu;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= REQ_CPU;
            starve      <= '0;
            sdr_addr_q  <= '0;
            sdr_64bit_q <= 1'b0;
            sdr_req_q   <= 1'b0;
            cpu_rdy_q   <= 1'b0;
            bg_rdy_q    <= 1'b0;
            // NOTE: the 64-bit data holders are plain registers, so clearing them on reset is cheap.
            cpu_data_q  <= '0;
            bg_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_bg) begin
                        sdr_addr_q  <= bus.bg_addr;
                        sdr_64bit_q <= bus.bg_64bit;
                        sdr_req_q   <= ~sdr_req_q;
                        owner       <= REQ_BG;
                        busy_q      <= 1'b1;
                        state       <= BG_WAIT;
                        if (pend_cpu)
                            starve <= (starve == STARVE_MAX) ? starve : starve + 1'b1;
                        else
                            starve <= '0;
                    end else if (grant_cpu) begin
                        sdr_addr_q  <= bus.cpu_addr;
                        sdr_64bit_q <= 1'b1;
                        sdr_req_q   <= ~sdr_req_q;
                        owner       <= REQ_CPU;
                        busy_q      <= 1'b1;
                        starve      <= '0;
                        state       <= CPU_WAIT;
                    end
                end
                CPU_WAIT: begin
                    if (bus.sdr_rdy == sdr_req_q) begin
                        cpu_data_q <= bus.sdr_data;
                        state      <= DONE;
                    end
                end
                BG_WAIT: begin
                    if (bus.sdr_rdy == sdr_req_q) begin
                        bg_data_q <= bus.sdr_data;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // One extra cycle so the next IDLE grant sees the refreshed rdy toggle.
                    if (owner == REQ_CPU) cpu_rdy_q <= ~cpu_rdy_q;
                    else                  bg_rdy_q  <= ~bg_rdy_q;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sdr_addr  = sdr_addr_q;
    assign bus.sdr_64bit = sdr_64bit_q;
    assign bus.sdr_req   = sdr_req_q;
    assign bus.cpu_rdy   = cpu_rdy_q;
    assign bus.cpu_data  = cpu_data_q;
    assign bus.bg_rdy    = bg_rdy_q;
    assign bus.bg_data   = bg_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: behavioural SDRAM controller, grant/data scoreboards,
// a table of single transactions and hand-written multi-cycle sequences.
module tb_sdram_arbiter;
    import board_pkg::*;

    localparam int ADDR_W = 25;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              b64;
    } grant_t;

    typedef struct {
        bit                is_cpu;
        logic [ADDR_W-1:0] addr;
        bit                b64;
        int                delay;
        bit                exp_64;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    sdram_arbiter #(.ADDR_W(ADDR_W), .BG_BURST_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    grant_t      exp_grant[$];
    logic [63:0] exp_cpu[$];
    logic [63:0] exp_bg[$];
    int grant_cyc[$];
    int cpu_rdy_cyc[$];
    int bg_rdy_cyc[$];
    int sdr_rdy_cyc[$];

    int                ctl_delay = 6;
    bit                ctl_busy  = 1'b0;
    int                ctl_cnt   = 0;
    logic [ADDR_W-1:0] ctl_addr  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] resp(input logic [ADDR_W-1:0] a);
        if (a == 25'h01_0000) return 64'h0123_4567_89AB_CDEF;
        return {39'(a) ^ 39'h3A_5A5A_5A5A, ~a};
    endfunction

    // Controller model: answers each outstanding request ctl_delay cycles after seeing it.
    always @(posedge clk) begin
        #3;
        if (reset) begin
            bus.sdr_rdy  = 1'b0;
            bus.sdr_data = '0;
            ctl_busy     = 1'b0;
        end else if (ctl_busy) begin
            if (ctl_cnt <= 1) begin
                bus.sdr_data = resp(ctl_addr);
                bus.sdr_rdy  = ~bus.sdr_rdy;
                sdr_rdy_cyc.push_back(cyc);
                ctl_busy = 1'b0;
            end else begin
                ctl_cnt--;
            end
        end else if (bus.sdr_req != bus.sdr_rdy) begin
            ctl_busy = 1'b1;
            ctl_cnt  = ctl_delay;
            ctl_addr = bus.sdr_addr;
        end
    end

    // Monitor: pops the scoreboards whenever a toggle moves.
    logic p_sdr_req, p_cpu_rdy, p_bg_rdy;
    always @(posedge clk) begin
        grant_t g;
        cyc++;
        #1;
        if (!reset) begin
            if (bus.sdr_req !== p_sdr_req) begin
                grant_cyc.push_back(cyc);
                check("grant_outstanding", 64'(bus.sdr_req ^ bus.sdr_rdy), 64'd1);
                if (exp_grant.size() == 0) begin
                    total++; bad++;
                    $display("FAIL grant_unexpected: got addr %h, want no grant", bus.sdr_addr);
                end else begin
                    g = exp_grant.pop_front();
                    check("grant_addr", 64'(bus.sdr_addr), 64'(g.addr));
                    check("grant_64bit", 64'(bus.sdr_64bit), 64'(g.b64));
                end
            end
            if (bus.cpu_rdy !== p_cpu_rdy) begin
                cpu_rdy_cyc.push_back(cyc);
                if (exp_cpu.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cpu_rdy_unexpected: got data %h, want no completion", bus.cpu_data);
                end else check("cpu_data", bus.cpu_data, exp_cpu.pop_front());
            end
            if (bus.bg_rdy !== p_bg_rdy) begin
                bg_rdy_cyc.push_back(cyc);
                if (exp_bg.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bg_rdy_unexpected: got data %h, want no completion", bus.bg_data);
                end else check("bg_data", bus.bg_data, exp_bg.pop_front());
            end
        end
        p_sdr_req = bus.sdr_req;
        p_cpu_rdy = bus.cpu_rdy;
        p_bg_rdy  = bus.bg_rdy;
    end

    task automatic clear_logs();
        grant_cyc.delete();
        cpu_rdy_cyc.delete();
        bg_rdy_cyc.delete();
        sdr_rdy_cyc.delete();
    endtask

    task automatic cpu_request(input logic [ADDR_W-1:0] a);
        bus.cpu_addr = a;
        bus.cpu_req  = ~bus.cpu_req;
        exp_cpu.push_back(resp(a));
    endtask

    task automatic bg_request(input logic [ADDR_W-1:0] a, input logic b64);
        bus.bg_addr  = a;
        bus.bg_64bit = b64;
        bus.bg_req   = ~bus.bg_req;
        exp_bg.push_back(resp(a));
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n = 0;
        bit quiet = 1'b0;
        while (!quiet && n < budget) begin
            @(negedge clk);
            n++;
            quiet = (exp_grant.size() == 0) && (exp_cpu.size() == 0) && (exp_bg.size() == 0)
                    && !bus.busy && !ctl_busy;
        end
        check({name, "_complete"}, 64'(quiet), 64'd1);
    endtask

    task automatic wait_done(input string name, input bit is_cpu, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = is_cpu ? (bus.cpu_rdy == bus.cpu_req) : (bus.bg_rdy == bus.bg_req);
        end
        if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_rdy"},   64'(bus.cpu_rdy),   64'd0);
        check({tag, "_bg_rdy"},    64'(bus.bg_rdy),    64'd0);
        check({tag, "_sdr_req"},   64'(bus.sdr_req),   64'd0);
        check({tag, "_sdr_addr"},  64'(bus.sdr_addr),  64'd0);
        check({tag, "_sdr_64bit"}, 64'(bus.sdr_64bit), 64'd0);
        check({tag, "_cpu_data"},  bus.cpu_data,       64'd0);
        check({tag, "_bg_data"},   bus.bg_data,        64'd0);
        check({tag, "_busy"},      64'(bus.busy),      64'd0);
        check({tag, "_state"},     64'(dut.state),     64'(IDLE));
        check({tag, "_starve"},    64'(dut.starve),    64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        logic [ADDR_W-1:0] sa[5];
        int c0;

        vt[0] = '{1'b1, 25'h001_0000, 1'b0, 6,  1'b1};
        vt[1] = '{1'b0, 25'h0AB_CDE0, 1'b1, 3,  1'b1};
        vt[2] = '{1'b0, 25'h1FF_FFF8, 1'b0, 1,  1'b0};
        vt[3] = '{1'b1, 25'h000_0000, 1'b0, 2,  1'b1};
        vt[4] = '{1'b1, 25'h1FF_FFFF, 1'b0, 10, 1'b1};

        reset        = 1'b1;
        bus.cpu_req  = 1'b0;
        bus.bg_req   = 1'b0;
        bus.cpu_addr = '0;
        bus.bg_addr  = '0;
        bus.bg_64bit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

        // Single transactions from the table.
        foreach (vt[i]) begin
            ctl_delay = vt[i].delay;
            clear_logs();
            @(negedge clk);
            c0 = cyc;
            exp_grant.push_back('{addr: vt[i].addr, b64: vt[i].exp_64});
            if (vt[i].is_cpu) cpu_request(vt[i].addr);
            else              bg_request(vt[i].addr, vt[i].b64);
            wait_quiet($sformatf("vec%0d", i), 60);
            if (grant_cyc.size() == 1 && sdr_rdy_cyc.size() == 1) begin
                check($sformatf("vec%0d_req_latency", i), 64'(grant_cyc[0] - c0), 64'd1);
                if (vt[i].is_cpu) begin
                    check($sformatf("vec%0d_rdy_latency", i), 64'(cpu_rdy_cyc.size() == 1 ? cpu_rdy_cyc[0] - sdr_rdy_cyc[0] : -1), 64'd2);
                    check($sformatf("vec%0d_bg_rdy_unchanged", i), 64'(bg_rdy_cyc.size()), 64'd0);
                end else begin
                    check($sformatf("vec%0d_rdy_latency", i), 64'(bg_rdy_cyc.size() == 1 ? bg_rdy_cyc[0] - sdr_rdy_cyc[0] : -1), 64'd2);
                    check($sformatf("vec%0d_cpu_rdy_unchanged", i), 64'(cpu_rdy_cyc.size()), 64'd0);
                end
            end else begin
                check($sformatf("vec%0d_grant_count", i), 64'(grant_cyc.size()), 64'd1);
            end
        end

        // Simultaneous requests: BG first, CPU in the IDLE cycle after bg_rdy flips.
        ctl_delay = 4;
        clear_logs();
        @(negedge clk);
        exp_grant.push_back('{addr: 25'h012_3450, b64: 1'b0});
        exp_grant.push_back('{addr: 25'h0C0_FFE8, b64: 1'b1});
        cpu_request(25'h0C0_FFE8);
        bg_request(25'h012_3450, 1'b0);
        wait_quiet("simul", 60);
        check("simul_cpu_after_bg", 64'(grant_cyc.size() == 2 && bg_rdy_cyc.size() == 1 ? grant_cyc[1] - bg_rdy_cyc[0] : -1), 64'd1);

        // Starvation: BG re-requests right after each completion; CPU forced in after 4 grants.
        ctl_delay = 2;
        clear_logs();
        for (int k = 0; k < 5; k++) sa[k] = ADDR_W'(25'h100_0000 + 25'(k * 8));
        for (int k = 0; k < 4; k++) exp_grant.push_back('{addr: sa[k], b64: 1'b1});
        exp_grant.push_back('{addr: 25'h000_4000, b64: 1'b1});
        exp_grant.push_back('{addr: sa[4], b64: 1'b1});
        @(negedge clk);
        cpu_request(25'h000_4000);
        bg_request(sa[0], 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_done($sformatf("starve_bg%0d", k), 1'b0, 40);
            if (k == 3) check("starve_at_limit", 64'(dut.starve), 64'd4);
            bg_request(sa[k + 1], 1'b1);
        end
        wait_quiet("starve", 100);
        check("starve_cleared", 64'(dut.starve), 64'd0);
        check("starve_bg_count", 64'(bg_rdy_cyc.size()), 64'd5);

        // No overlap: BG arrives during a long CPU_WAIT and is served next.
        ctl_delay = 20;
        clear_logs();
        exp_grant.push_back('{addr: 25'h003_3330, b64: 1'b1});
        exp_grant.push_back('{addr: 25'h155_5550, b64: 1'b0});
        @(negedge clk);
        cpu_request(25'h003_3330);
        repeat (5) @(negedge clk);
        bg_request(25'h155_5550, 1'b0);
        repeat (10) @(negedge clk);
        check("overlap_single_grant", 64'(grant_cyc.size()), 64'd1);
        wait_quiet("overlap", 100);
        check("overlap_bg_next", 64'(grant_cyc.size() == 2 && cpu_rdy_cyc.size() == 1 ? grant_cyc[1] - cpu_rdy_cyc[0] : -1), 64'd1);

        // Reset during BG_WAIT, then a fresh CPU request.
        ctl_delay = 20;
        clear_logs();
        exp_grant.push_back('{addr: 25'h0F0_0F00, b64: 1'b1});
        @(negedge clk);
        bg_request(25'h0F0_0F00, 1'b1);
        repeat (4) @(negedge clk);
        check("rst_in_bg_wait", 64'(dut.state), 64'(BG_WAIT));
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        bus.bg_req  = 1'b0;
        exp_grant.delete();
        exp_cpu.delete();
        exp_bg.delete();
        @(posedge clk);
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        ctl_delay = 3;
        clear_logs();
        exp_grant.push_back('{addr: 25'h002_0000, b64: 1'b1});
        @(negedge clk);
        cpu_request(25'h002_0000);
        wait_quiet("post_rst", 60);

        // Back-to-back CPU: second request 1 clk after the first cpu_rdy flip.
        ctl_delay = 3;
        clear_logs();
        exp_grant.push_back('{addr: 25'h004_0000, b64: 1'b1});
        exp_grant.push_back('{addr: 25'h004_0040, b64: 1'b1});
        @(negedge clk);
        cpu_request(25'h004_0000);
        wait_done("b2b_first", 1'b1, 40);
        cpu_request(25'h004_0040);
        wait_quiet("b2b", 60);
        check("b2b_rdy_count", 64'(cpu_rdy_cyc.size()), 64'd2);
        check("b2b_regrant", 64'(grant_cyc.size() == 2 && cpu_rdy_cyc.size() >= 1 ? grant_cyc[1] - cpu_rdy_cyc[0] : -1), 64'd1);
        check("b2b_bg_quiet", 64'(bg_rdy_cyc.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
